bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 1, number of extra access-latency cycles inserted before the response; range 0..15.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  requester presents a request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_op  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (RV32 funct3 encoding).
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  requester consumes the response.
REQ-013 rsp_rdata  output  32  load result after extension; 0 for stores and faults.
REQ-014 rsp_fault  output  1  request faulted.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request is accepted on the edge where req_valid & req_ready; the responder SHALL latch req_write, req_op, req_addr and req_wdata on that edge.
REQ-018 On acceptance the FSM SHALL go IDLE->WAIT and load its counter with WAIT_CYCLES; with WAIT_CYCLES=0 it SHALL go IDLE->RESP directly.
REQ-019 In WAIT the counter SHALL decrement each cycle; the FSM SHALL go WAIT->RESP when the counter reaches 1.
REQ-020 Latency: rsp_valid SHALL first be high in cycle N+1+WAIT_CYCLES, where N is the acceptance cycle.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_fault SHALL stay stable until rsp_valid & rsp_ready.
REQ-022 On the RESP edge where rsp_ready is 1, the FSM SHALL return to IDLE.
REQ-023 There SHALL be no same-cycle response-and-accept: the earliest next acceptance is the cycle after RESP exits.
REQ-024 Faults SHALL be computed from the latched request:
- illegal op: req_op in {011, 110, 111}, or a store with req_op[2]=1;
- misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0;
- out of range: addr ≥ DEPTH_WORDS*4.
REQ-025 A faulting request SHALL leave the array unchanged and SHALL return rsp_fault=1 and rsp_rdata=0, with normal latency.
REQ-026 Loads SHALL be little-endian:
- B/H SHALL be sign-extended from bit 7/15;
- BU/HU SHALL be zero-extended.
REQ-027 Stores SHALL merge only the addressed byte lanes (B: 1 lane, H: 2 lanes, W: 4 lanes) and leave the other lanes unchanged.
REQ-028 A store SHALL be written to the array exactly once, on the edge that enters RESP.
REQ-029 The load value SHALL be captured on that same edge.
REQ-030 Requests presented while req_ready=0 SHALL be ignored and have no side effect.

Reset
REQ-031 On reset, the FSM SHALL go to IDLE, the counter to 0, and rsp_valid, rsp_fault and rsp_rdata to 0; req_ready SHALL be 1 in the first cycle after reset.
REQ-032 Reset in WAIT or RESP SHALL abandon the transaction, with no array write and no response.
REQ-033 Array contents SHALL NOT be cleared by reset.

Structure
REQ-034 The op encodings and the FSM state enum SHALL be defined in shared package bus_pkg, reused by the core-side requester.
REQ-035 Byte-lane extract/extend and store merge SHALL be in one combinational sub-module, bus_lane_align.
REQ-036 The array SHALL be a single-port word array indexed by addr[log2(DEPTH_WORDS)+1:2].

Verification
REQ-037 Scenario: SW 0xDEADBEEF @0x10, then LW @0x10, WAIT_CYCLES=1 -> rdata 0xDEADBEEF, fault 0, rsp_valid 2 cycles after acceptance.
REQ-038 Scenario: after REQ-037, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LHU @0x10 -> 0x0000BEEF.
REQ-039 Scenario: SH 0x1234 @0x12, then LW @0x10 -> 0x1234BEEF.
REQ-040 Scenario: LW @0x02, SH @0x11, LB @DEPTH_WORDS*4 and op 011 -> each fault 1, rdata 0; a following LW @0x10 returns unchanged data.
REQ-041 Scenario: rsp_ready held 0 for 3 cycles in RESP -> rsp_valid/rdata/fault stable; req_ready 0 throughout; req_valid pulses during this time are ignored.
REQ-042 Scenario: reset asserted in WAIT of SW 0xCAFEF00D @0x20 -> next cycle IDLE, req_ready 1, no response; LW @0x20 returns the prior contents.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: RV32 funct3 access encodings and the responder FSM states.
// Also imported by the core-side requester.
package bus_pkg;

    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/bus_lane_align.sv
// Byte-lane handling for a 32-bit little-endian word.
// Produces the extended load value and the merged store word.
module bus_lane_align
    import bus_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] word_sh;
    logic [31:0] wdata_sh;
    logic [31:0] lane_mask;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    assign shamt    = {byte_off, 3'b000};
    assign word_sh  = word >> shamt;
    assign wdata_sh = wdata << shamt;

    // op[2] distinguishes unsigned loads; the width lives in op[1:0]
    always_comb begin
        rdata = word_sh;
        unique case (op[1:0])
            2'b00:   rdata = op[2] ? {24'd0, word_sh[7:0]}
                                   : {{24{word_sh[7]}}, word_sh[7:0]};
            2'b01:   rdata = op[2] ? {16'd0, word_sh[15:0]}
                                   : {{16{word_sh[15]}}, word_sh[15:0]};
            default: rdata = word_sh;
        endcase
    end

    always_comb begin
        byte_mask = 32'h0000_00FF;
        half_mask = 32'h0000_FFFF;
        lane_mask = 32'hFFFF_FFFF;
        unique case (op[1:0])
            2'b00:   lane_mask = byte_mask << shamt;
            2'b01:   lane_mask = half_mask << shamt;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    end

    assign merged = (word & ~lane_mask) | (wdata_sh & lane_mask);

endmodule

// File: rtl/bus_responder.sv
// Single-port word-array bus responder with programmable access latency,
// byte/half/word loads and stores, and fault detection.
module bus_responder
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        enter_resp;
    logic        accept;

    logic        lat_write;
    logic [2:0]  lat_op;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        acc_write;
    logic [2:0]  acc_op;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    logic        illegal, misaligned, out_range, fault;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_op    <= req_op;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // With zero wait cycles the access happens on the accept edge, before the latch is valid
    assign acc_write = (state == ST_IDLE) ? req_write : lat_write;
    assign acc_op    = (state == ST_IDLE) ? req_op    : lat_op;
    assign acc_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;

    assign illegal    = (acc_op == 3'b011) || (acc_op[2:1] == 2'b11) || (acc_write && acc_op[2]);
    assign misaligned = ((acc_op[1:0] == 2'b01) && acc_addr[0])
                     || ((acc_op[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
    assign out_range  = |acc_addr[31:AW+2];
    assign fault      = illegal | misaligned | out_range;

    assign idx     = acc_addr[AW+1:2];
    assign rd_word = mem[idx];

    bus_lane_align u_lane_align (
        .op       (acc_op),
        .byte_off (acc_addr[1:0]),
        .word     (rd_word),
        .wdata    (acc_wdata),
        .rdata    (ld_data),
        .merged   (st_word)
    );

    always_ff @(posedge clk) begin
        if (enter_resp && !reset && acc_write && !fault) begin
            mem[idx] <= st_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= 32'd0;
            rsp_fault <= 1'b0;
        end else if (enter_resp) begin
            rsp_fault <= fault;
            rsp_rdata <= (fault || acc_write) ? 32'd0 : ld_data;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder with WAIT_CYCLES=1 and DEPTH_WORDS=1024.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int n_chk  = 0;
    int n_pass = 0;

    bus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    // One full transaction; optional stall cycles in RESP with ignored request pulses.
    task automatic xact(input logic w, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output logic flt, output int lat);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_op = 3'b0; req_addr = 32'd0; req_wdata = 32'd0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        rd  = rsp_rdata;
        flt = rsp_fault;
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_op = 3'b010;
            req_addr = 32'h10; req_wdata = 32'd0;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, rd);
            check("stall_fault", 32'(rsp_fault), 32'(flt));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("idle_after_resp", {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic w, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_flt);
        logic [31:0] rd;
        logic        flt;
        int          lat;
        xact(w, op, addr, wd, 0, rd, flt, lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_fault"}, 32'(flt), 32'(exp_flt));
        check({tag, "_lat"}, 32'(lat), 32'd2);
    endtask

    initial begin
        logic [31:0] rd;
        logic        flt;
        int          lat;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_op = 3'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);

        run("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        run("lw_10",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        run("lb_13",  1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
        run("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0);
        run("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
        run("lh_10",  1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
        run("lb_10",  1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);

        run("sh_12",  1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0,        1'b0);
        run("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0,        32'h1234BEEF, 1'b0);
        run("lh_12",  1'b0, 3'b001, 32'h12, 32'h0,        32'h00001234, 1'b0);
        run("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0,        32'h000000BE, 1'b0);

        run("f_lw_02",   1'b0, 3'b010, 32'h02,   32'h0,        32'h0, 1'b1);
        run("f_sh_11",   1'b1, 3'b001, 32'h11,   32'hFFFFFFFF, 32'h0, 1'b1);
        run("f_lb_top",  1'b0, 3'b000, 32'h1000, 32'h0,        32'h0, 1'b1);
        run("f_op011",   1'b0, 3'b011, 32'h10,   32'h0,        32'h0, 1'b1);
        run("f_st_bu",   1'b1, 3'b100, 32'h10,   32'h0,        32'h0, 1'b1);
        run("lw_10_chk", 1'b0, 3'b010, 32'h10,   32'h0,        32'h1234BEEF, 1'b0);

        run("sw_ffc", 1'b1, 3'b010, 32'hFFC, 32'h0BADF00D, 32'h0,        1'b0);
        run("lw_ffc", 1'b0, 3'b010, 32'hFFC, 32'h0,        32'h0BADF00D, 1'b0);

        xact(1'b0, 3'b010, 32'h10, 32'h0, 3, rd, flt, lat);
        check("stall_lw_rdata", rd, 32'h1234BEEF);
        check("stall_lw_lat", 32'(lat), 32'd2);
        run("lw_after_stall", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

        run("sw_20",  1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0,        1'b0);
        run("sb_21",  1'b1, 3'b000, 32'h21, 32'hFFFFFFAA, 32'h0,        1'b0);
        run("lw_20",  1'b0, 3'b010, 32'h20, 32'h0,        32'h1122AA44, 1'b0);

        req_valid = 1'b1; req_write = 1'b1; req_op = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wait_req_ready", 32'(req_ready), 32'd0);
        check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        run("lw_20_after_rst", 1'b0, 3'b010, 32'h20, 32'h0, 32'h1122AA44, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
